vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Configuration sequencer for the hires VGA/HDMI sync and line-doubler block.
- Holds CPU-written shadow copies of the timing, mode and polarity settings and validates them against the selected chip's raster geometry.
- Commits validated settings atomically at the frame boundary (raster_x==0 && raster_y==0) and toggles timing_change_out so the sync block reloads its parameters exactly once per commit.
- Sits between the register file and the sync block.

Parameters:
- H_BASE, 384, constant added to h_blank to form the active-end column.
- PAL_V_BASE, 256, constant added to v_blank on PAL chips.

Ports:
- clk_dot4x  in  1  4x dot clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- chip  in  2  chip select (CHIP6569R1/R3, CHIP6567R8, CHIP6567R56A).
- raster_x  in  10  native raster column.
- raster_y  in  9  native raster line.
- reg_we  in  1  register write strobe, one cycle.
- reg_addr  in  4  0-7 = h_blank, h_fporch, h_sync, h_bporch, v_blank, v_fporch, v_sync, v_bporch; 8 = mode; 9 = commit.
- reg_din  in  8  write data; mode bits are [0] native_x, [1] native_y, [2] hpol, [3] vpol, [4] csync.
- timing_h_blank .. timing_v_bporch  out  8 each  live timing values (8 ports).
- is_native_x_out, is_native_y_out, hpolarity, vpolarity, enable_csync  out  1 each  live mode.
- timing_change_out  out  1  toggles once per successful commit.
- busy  out  1  high while a commit is pending or being applied.
- cfg_error  out  1  sticky; set by a rejected commit, cleared by the next accepted commit.

Behaviour:
- Reset (async assert, sync release):
  - Shadow and live timing load PAL defaults: h_blank 110, h_fporch 20, h_sync 38, h_bporch 42, v_blank 44, v_fporch 1, v_sync 8, v_bporch 1.
  - Mode resets to native_x=0, native_y=0, hpol=0, vpol=0, csync=0.
  - timing_change_out=0, busy=0, cfg_error=0, FSM=IDLE.
- Writes to addr 0-8 update shadow only, in any state, effective next cycle. Addr 10-15 are ignored.
- FSM:
  - IDLE: a write to addr 9 goes to PEND; busy asserts the next cycle.
  - PEND: waits for frame start (raster_x==0 && raster_y==0 sampled this cycle), then goes to CHECK.
  - CHECK (1 cycle): computes hsum = h_fporch+h_sync+h_bporch and vsum = v_blank+v_fporch+v_sync+v_bporch, both 10-bit, no overflow.
    - Pass requires all of: h_sync!=0, v_sync!=0, hsum <= HLIM(chip), vsum <= VLIM(chip).
    - HLIM: PAL 120, R8 136, R56A 128.
    - VLIM: PAL 55, R8 262, R56A 261.
    - Pass goes to APPLY. Fail sets cfg_error, leaves live values unchanged, goes to HOLD.
  - APPLY (1 cycle): copies all shadow values to live, toggles timing_change_out, clears cfg_error, goes to HOLD.
  - HOLD: stays while raster_x==0 && raster_y==0; otherwise returns to IDLE with busy=0. This guarantees at most one commit per frame start.
- Latency: live outputs change 2 cycles after the frame-start cycle is seen in PEND.
- Commit written while busy: latched as a pending flag. On return to IDLE the FSM goes directly to PEND, which applies the newest shadow on the next frame.
- Shadow writes during PEND or CHECK are included in that commit. Writes landing in APPLY take effect next commit only.
- chip change: takes effect at the next CHECK only. Live values are never re-validated.
- Reset mid-commit: abandons the commit, restores defaults, and forces timing_change_out=0.

Optional Feature:
- VGA_TIMING_READBACK_EN
  - Defined: adds ports reg_re (in 1) and reg_dout (out 8).
    - reg_dout is registered, 1-cycle latency after reg_re.
    - Addr 0-8 return shadow values.
    - Addr 9 returns {6'b0, cfg_error, busy}.
    - Addr 10-15 return 0.
    - reg_dout resets to 0.
  - Undefined: neither port exists; all else identical.

Decomposition:
- Shared package vga_timing_pkg:
  - CHIP codes.
  - Register address constants (ADDR_H_BLANK..ADDR_COMMIT).
  - Default timing constants.
  - HLIM/VLIM per chip.
  - FSM state enum (IDLE, PEND, CHECK, APPLY, HOLD).
- One sub-module is natural: vga_timing_check. It is combinational and takes chip plus the 8 shadow values, producing pass.

Test Plan:
- Reset, then release: live = 110/20/38/42/44/1/8/1, all mode bits 0, timing_change_out=0, busy=0.
- PAL: write h_blank=100, commit, frame start at cycle N → live h_blank=100 at N+2, timing_change_out toggles once, busy drops once raster leaves (0,0).
- PAL: write h_sync=0, commit, frame start → cfg_error=1, live unchanged, no toggle. Then write h_sync=38, commit → cfg_error clears on apply.
- Chip R8: v_blank=250, v_fporch=5, v_sync=8, v_bporch=0 (vsum 263 > 262) → rejected. Then v_bporch=0 with v_blank=249 (vsum 262) → accepted.
- Two commits written within one frame (second while busy) → exactly one toggle per frame start. Second commit applies on the following frame using the latest shadow.
- rst_n asserted during PEND → outputs return to defaults immediately (async), no toggle after release. With VGA_TIMING_READBACK_EN, read addr 9 shows 0x00.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// +-----------------------------------------------------------------------------+
// | vga_timing_pkg - shared constants, types and chip limits for vga_timing_ctrl |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam logic [1:0] CHIP6569R3   = 2'd0;
  localparam logic [1:0] CHIP6567R8   = 2'd1;
  localparam logic [1:0] CHIP6567R56A = 2'd2;
  localparam logic [1:0] CHIP6569R1   = 2'd3;

  localparam logic [3:0] ADDR_H_BLANK  = 4'd0;
  localparam logic [3:0] ADDR_H_FPORCH = 4'd1;
  localparam logic [3:0] ADDR_H_SYNC   = 4'd2;
  localparam logic [3:0] ADDR_H_BPORCH = 4'd3;
  localparam logic [3:0] ADDR_V_BLANK  = 4'd4;
  localparam logic [3:0] ADDR_V_FPORCH = 4'd5;
  localparam logic [3:0] ADDR_V_SYNC   = 4'd6;
  localparam logic [3:0] ADDR_V_BPORCH = 4'd7;
  localparam logic [3:0] ADDR_MODE     = 4'd8;
  localparam logic [3:0] ADDR_COMMIT   = 4'd9;

  localparam logic [7:0] DEF_H_BLANK  = 8'd110;
  localparam logic [7:0] DEF_H_FPORCH = 8'd20;
  localparam logic [7:0] DEF_H_SYNC   = 8'd38;
  localparam logic [7:0] DEF_H_BPORCH = 8'd42;
  localparam logic [7:0] DEF_V_BLANK  = 8'd44;
  localparam logic [7:0] DEF_V_FPORCH = 8'd1;
  localparam logic [7:0] DEF_V_SYNC   = 8'd8;
  localparam logic [7:0] DEF_V_BPORCH = 8'd1;

  // Element index equals the register address of that timing field.
  typedef logic [7:0][7:0] timing_t;

  localparam timing_t TIMING_DEFAULT = {DEF_V_BPORCH, DEF_V_SYNC, DEF_V_FPORCH, DEF_V_BLANK,
                                        DEF_H_BPORCH, DEF_H_SYNC, DEF_H_FPORCH, DEF_H_BLANK};

  typedef struct packed {
    logic csync;
    logic vpol;
    logic hpol;
    logic native_y;
    logic native_x;
  } mode_t;

  typedef enum logic [2:0] {IDLE, PEND, CHECK, APPLY, HOLD} state_t;

  function automatic logic [9:0] hlim(input logic [1:0] chip);
    case (chip)
      CHIP6567R8:   hlim = 10'd136;
      CHIP6567R56A: hlim = 10'd128;
      default:      hlim = 10'd120;
    endcase
  endfunction

  function automatic logic [9:0] vlim(input logic [1:0] chip);
    case (chip)
      CHIP6567R8:   vlim = 10'd262;
      CHIP6567R56A: vlim = 10'd261;
      default:      vlim = 10'd55;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_check.sv
// +-----------------------------------------------------------------------------+
// | vga_timing_check - combinational validation of shadow timing vs chip limits  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vga_timing_check
  import vga_timing_pkg::*;
(
  input  logic [1:0] chip,
  input  timing_t    shadow,
  output logic       pass
);

  logic [9:0] hsum;
  logic [9:0] vsum;
  logic [7:0] unused_h_blank;

  // h_blank only positions the active area, so it takes no part in the sums.
  assign unused_h_blank = shadow[0];

  assign hsum = 10'(shadow[1]) + 10'(shadow[2]) + 10'(shadow[3]);
  assign vsum = 10'(shadow[4]) + 10'(shadow[5]) + 10'(shadow[6]) + 10'(shadow[7]);

  assign pass = (shadow[2] != 8'd0) && (shadow[6] != 8'd0) &&
                (hsum <= hlim(chip)) && (vsum <= vlim(chip));

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// +-----------------------------------------------------------------------------+
// | vga_timing_ctrl - shadow/live timing sequencer, commits at frame start;      |
// | optional register readback via VGA_TIMING_READBACK_EN.  Rev 1.0              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_BASE     = 384,
  parameter int PAL_V_BASE = 256
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic [1:0] chip,
  input  logic [9:0] raster_x,
  input  logic [8:0] raster_y,
  input  logic       reg_we,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic [7:0] timing_h_blank,
  output logic [7:0] timing_h_fporch,
  output logic [7:0] timing_h_sync,
  output logic [7:0] timing_h_bporch,
  output logic [7:0] timing_v_blank,
  output logic [7:0] timing_v_fporch,
  output logic [7:0] timing_v_sync,
  output logic [7:0] timing_v_bporch,
  output logic       is_native_x_out,
  output logic       is_native_y_out,
  output logic       hpolarity,
  output logic       vpolarity,
  output logic       enable_csync,
  output logic       timing_change_out,
  output logic       busy,
  output logic       cfg_error
`ifdef VGA_TIMING_READBACK_EN
  ,
  input  logic       reg_re,
  output logic [7:0] reg_dout
`endif
);

  timing_t shadow;
  timing_t live;
  mode_t   mode_shadow;
  mode_t   mode_live;
  state_t  state;
  logic    pending;
  logic    pass;
  logic    frame_start;
  logic    commit_req;

  // Active-end coordinates belong to the sync block; only kept here for reference.
  logic [9:0] unused_active_end;
  logic [2:0] unused_din;
  assign unused_active_end = (10'(H_BASE) + 10'(live[0])) ^ (10'(PAL_V_BASE) + 10'(live[4]));
  assign unused_din        = reg_din[7:5];

  assign frame_start = (raster_x == 10'd0) && (raster_y == 9'd0);
  assign commit_req  = reg_we && (reg_addr == ADDR_COMMIT);

  vga_timing_check u_check (
    .chip   (chip),
    .shadow (shadow),
    .pass   (pass)
  );

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      shadow            <= TIMING_DEFAULT;
      live              <= TIMING_DEFAULT;
      mode_shadow       <= '0;
      mode_live         <= '0;
      state             <= IDLE;
      pending           <= 1'b0;
      busy              <= 1'b0;
      cfg_error         <= 1'b0;
      timing_change_out <= 1'b0;
    end else begin
      if (reg_we && !reg_addr[3]) shadow[reg_addr[2:0]] <= reg_din;
      if (reg_we && (reg_addr == ADDR_MODE)) mode_shadow <= mode_t'(reg_din[4:0]);
      if (commit_req && (state != IDLE)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (commit_req) begin
            state <= PEND;
            busy  <= 1'b1;
          end
        end
        PEND: begin
          if (frame_start) state <= CHECK;
        end
        CHECK: begin
          if (pass) begin
            state <= APPLY;
          end else begin
            cfg_error <= 1'b1;
            state     <= HOLD;
          end
        end
        APPLY: begin
          live              <= shadow;
          mode_live         <= mode_shadow;
          timing_change_out <= ~timing_change_out;
          cfg_error         <= 1'b0;
          state             <= HOLD;
        end
        HOLD: begin
          // A queued commit skips IDLE and waits for the next frame start.
          if (!frame_start) begin
            if (pending || commit_req) begin
              state   <= PEND;
              pending <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_TIMING_READBACK_EN
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      reg_dout <= 8'd0;
    end else if (reg_re) begin
      if (!reg_addr[3])                 reg_dout <= shadow[reg_addr[2:0]];
      else if (reg_addr == ADDR_MODE)   reg_dout <= {3'b000, mode_shadow};
      else if (reg_addr == ADDR_COMMIT) reg_dout <= {6'b0, cfg_error, busy};
      else                              reg_dout <= 8'd0;
    end
  end
`endif

  assign timing_h_blank  = live[0];
  assign timing_h_fporch = live[1];
  assign timing_h_sync   = live[2];
  assign timing_h_bporch = live[3];
  assign timing_v_blank  = live[4];
  assign timing_v_fporch = live[5];
  assign timing_v_sync   = live[6];
  assign timing_v_bporch = live[7];

  assign is_native_x_out = mode_live.native_x;
  assign is_native_y_out = mode_live.native_y;
  assign hpolarity       = mode_live.hpol;
  assign vpolarity       = mode_live.vpol;
  assign enable_csync    = mode_live.csync;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_vga_timing_ctrl - directed self-checking bench for vga_timing_ctrl        |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  logic       clk_dot4x = 1'b0;
  logic       rst_n;
  logic [1:0] chip;
  logic [9:0] raster_x;
  logic [8:0] raster_y;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_din;
  logic [7:0] timing_h_blank, timing_h_fporch, timing_h_sync, timing_h_bporch;
  logic [7:0] timing_v_blank, timing_v_fporch, timing_v_sync, timing_v_bporch;
  logic       is_native_x_out, is_native_y_out, hpolarity, vpolarity, enable_csync;
  logic       timing_change_out, busy, cfg_error;
`ifdef VGA_TIMING_READBACK_EN
  logic       reg_re;
  logic [7:0] reg_dout;
`endif

  int checks = 0;
  int errors = 0;

  vga_timing_ctrl dut (
    .clk_dot4x         (clk_dot4x),
    .rst_n             (rst_n),
    .chip              (chip),
    .raster_x          (raster_x),
    .raster_y          (raster_y),
    .reg_we            (reg_we),
    .reg_addr          (reg_addr),
    .reg_din           (reg_din),
    .timing_h_blank    (timing_h_blank),
    .timing_h_fporch   (timing_h_fporch),
    .timing_h_sync     (timing_h_sync),
    .timing_h_bporch   (timing_h_bporch),
    .timing_v_blank    (timing_v_blank),
    .timing_v_fporch   (timing_v_fporch),
    .timing_v_sync     (timing_v_sync),
    .timing_v_bporch   (timing_v_bporch),
    .is_native_x_out   (is_native_x_out),
    .is_native_y_out   (is_native_y_out),
    .hpolarity         (hpolarity),
    .vpolarity         (vpolarity),
    .enable_csync      (enable_csync),
    .timing_change_out (timing_change_out),
    .busy              (busy),
    .cfg_error         (cfg_error)
`ifdef VGA_TIMING_READBACK_EN
    ,
    .reg_re            (reg_re),
    .reg_dout          (reg_dout)
`endif
  );

  always #5 clk_dot4x = ~clk_dot4x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dot4x);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    reg_we   = 1'b1;
    reg_addr = addr;
    reg_din  = data;
    tick();
    reg_we   = 1'b0;
  endtask

  task automatic set_raster(input logic [9:0] x, input logic [8:0] y);
    raster_x = x;
    raster_y = y;
  endtask

  // Commit, present one frame start, then leave (0,0) so the FSM returns to IDLE.
  task automatic frame_commit();
    wr(ADDR_COMMIT, 8'd0);
    tick();
    set_raster(10'd0, 9'd0);
    tick();
    tick();
    tick();
    set_raster(10'd1, 9'd0);
    tick();
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_hb"}, timing_h_blank, 110);
    chk({tag, "_hf"}, timing_h_fporch, 20);
    chk({tag, "_hs"}, timing_h_sync, 38);
    chk({tag, "_hp"}, timing_h_bporch, 42);
    chk({tag, "_vb"}, timing_v_blank, 44);
    chk({tag, "_vf"}, timing_v_fporch, 1);
    chk({tag, "_vs"}, timing_v_sync, 8);
    chk({tag, "_vp"}, timing_v_bporch, 1);
    chk({tag, "_mode"}, {enable_csync, vpolarity, hpolarity, is_native_y_out, is_native_x_out}, 0);
    chk({tag, "_tog"}, timing_change_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, cfg_error, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    chip     = CHIP6569R3;
    reg_we   = 1'b0;
    reg_addr = 4'd0;
    reg_din  = 8'd0;
`ifdef VGA_TIMING_READBACK_EN
    reg_re   = 1'b0;
`endif
    set_raster(10'd5, 9'd5);
    repeat (3) tick();
    chk_defaults("rst_in");
    rst_n = 1'b1;
    repeat (2) tick();
    chk_defaults("rst_out");

    // PAL h_blank change with exact latency from the frame-start edge
    wr(ADDR_H_BLANK, 8'd100);
    chk("t1_idle_busy", busy, 0);
    wr(ADDR_COMMIT, 8'd0);
    chk("t1_busy_set", busy, 1);
    repeat (3) tick();
    chk("t1_wait_hb", timing_h_blank, 110);
    set_raster(10'd0, 9'd0);
    tick();
    chk("t1_n_hb", timing_h_blank, 110);
    tick();
    chk("t1_n1_hb", timing_h_blank, 110);
    chk("t1_n1_tog", timing_change_out, 0);
    tick();
    chk("t1_n2_hb", timing_h_blank, 100);
    chk("t1_n2_tog", timing_change_out, 1);
    tick();
    chk("t1_hold_busy", busy, 1);
    chk("t1_hold_tog", timing_change_out, 1);
    set_raster(10'd1, 9'd0);
    tick();
    chk("t1_done_busy", busy, 0);
    repeat (3) tick();
    chk("t1_one_toggle", timing_change_out, 1);

    // h_sync = 0 is rejected, then restoring it is accepted
    wr(ADDR_H_SYNC, 8'd0);
    frame_commit();
    chk("t2_rej_err", cfg_error, 1);
    chk("t2_rej_hs", timing_h_sync, 38);
    chk("t2_rej_tog", timing_change_out, 1);
    chk("t2_rej_busy", busy, 0);
    wr(ADDR_H_SYNC, 8'd38);
    frame_commit();
    chk("t2_acc_err", cfg_error, 0);
    chk("t2_acc_hs", timing_h_sync, 38);
    chk("t2_acc_hb", timing_h_blank, 100);
    chk("t2_acc_tog", timing_change_out, 0);

    // R8 vertical limit 262: 263 rejected, 262 accepted together with mode bits
    chip = CHIP6567R8;
    wr(ADDR_V_BLANK, 8'd250);
    wr(ADDR_V_FPORCH, 8'd5);
    wr(ADDR_V_SYNC, 8'd8);
    wr(ADDR_V_BPORCH, 8'd0);
    frame_commit();
    chk("t3_rej_err", cfg_error, 1);
    chk("t3_rej_vb", timing_v_blank, 44);
    chk("t3_rej_tog", timing_change_out, 0);
    wr(ADDR_V_BLANK, 8'd249);
    wr(ADDR_MODE, 8'hF5);
    frame_commit();
    chk("t3_acc_err", cfg_error, 0);
    chk("t3_acc_vb", timing_v_blank, 249);
    chk("t3_acc_vp", timing_v_bporch, 0);
    chk("t3_acc_vf", timing_v_fporch, 5);
    chk("t3_acc_mode", {enable_csync, vpolarity, hpolarity, is_native_y_out, is_native_x_out}, 5'b10101);
    chk("t3_acc_tog", timing_change_out, 1);

    // second commit while busy: one toggle per frame start, latest shadow next frame
    wr(ADDR_H_BLANK, 8'd90);
    wr(ADDR_COMMIT, 8'd0);
    set_raster(10'd0, 9'd0);
    repeat (3) tick();
    chk("t4_first_hb", timing_h_blank, 90);
    chk("t4_first_tog", timing_change_out, 0);
    wr(ADDR_H_BLANK, 8'd80);
    wr(ADDR_COMMIT, 8'd0);
    set_raster(10'd7, 9'd3);
    tick();
    chk("t4_requeue_busy", busy, 1);
    repeat (4) tick();
    chk("t4_no_extra_tog", timing_change_out, 0);
    chk("t4_wait_hb", timing_h_blank, 90);
    set_raster(10'd0, 9'd0);
    repeat (3) tick();
    chk("t4_second_hb", timing_h_blank, 80);
    chk("t4_second_tog", timing_change_out, 1);
    set_raster(10'd1, 9'd0);
    tick();
    chk("t4_idle_busy", busy, 0);

    // asynchronous reset while a commit is pending
    wr(ADDR_H_BLANK, 8'd70);
    wr(ADDR_COMMIT, 8'd0);
    chk("t5_pend_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_defaults("t5_async");
    tick();
    rst_n = 1'b1;
    set_raster(10'd0, 9'd0);
    repeat (4) tick();
    chk("t5_after_tog", timing_change_out, 0);
    chk("t5_after_hb", timing_h_blank, 110);
    chk("t5_after_busy", busy, 0);
`ifdef VGA_TIMING_READBACK_EN
    reg_re   = 1'b1;
    reg_addr = ADDR_COMMIT;
    tick();
    chk("t5_rd_status", reg_dout, 8'h00);
    reg_addr = ADDR_H_BLANK;
    tick();
    chk("t5_rd_hb", reg_dout, 8'd110);
    reg_re   = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
